// File: rtl/sram_byte_bridge.sv
// Byte-wide SoC bus to 16-bit SRAM word bridge; byte stores are done as read-modify-write.
// Define WORD_CACHE_EN to build a one-entry word cache that lets hits skip the SRAM read.
module sram_byte_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  FILL_BYTE      = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] bus_addr,
    input  logic [7:0]  bus_do,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [7:0]  bus_di,
    output logic        bus_ack,
    output logic        bus_err,
    output logic        busy,
    output logic [17:0] sram_address,
    output logic [15:0] sram_data_write,
    input  logic [15:0] sram_data_read,
    output logic        sram_read,
    output logic        sram_write,
    input  logic        sram_ready
);
    typedef enum logic [2:0] {IDLE, RD, WRD, WWR, ACK} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic        lane, lane_n;
    logic [7:0]  wbyte, wbyte_n;
    logic [15:0] tcnt, tcnt_n;
    logic        tmo;

    logic [7:0]  bus_di_n;
    logic        bus_ack_n, bus_err_n, busy_n, sram_read_n, sram_write_n;
    logic [17:0] sram_address_n;
    logic [15:0] sram_data_write_n;

    function automatic logic [15:0] merge(input logic [15:0] w, input logic l, input logic [7:0] b);
        return l ? {b, w[7:0]} : {w[15:8], b};
    endfunction

    function automatic logic [7:0] pick(input logic [15:0] w, input logic l);
        return l ? w[15:8] : w[7:0];
    endfunction

`ifdef WORD_CACHE_EN
    logic        cvalid, cvalid_n;
    logic [17:0] ctag, ctag_n;
    logic [15:0] cdata, cdata_n;
    logic        hit;

    assign hit = cvalid && (ctag == bus_addr[18:1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            cvalid <= 1'b0;
            ctag   <= '0;
            cdata  <= '0;
        end else begin
            cvalid <= cvalid_n;
            ctag   <= ctag_n;
            cdata  <= cdata_n;
        end
    end
`endif

    // The counter only matters while a strobe is up; it is cleared whenever one starts.
    assign tmo = (tcnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            lane            <= 1'b0;
            wbyte           <= '0;
            tcnt            <= '0;
            bus_di          <= '0;
            bus_ack         <= 1'b0;
            bus_err         <= 1'b0;
            busy            <= 1'b0;
            sram_read       <= 1'b0;
            sram_write      <= 1'b0;
            sram_address    <= '0;
            sram_data_write <= '0;
        end else begin
            state           <= state_n;
            lane            <= lane_n;
            wbyte           <= wbyte_n;
            tcnt            <= tcnt_n;
            bus_di          <= bus_di_n;
            bus_ack         <= bus_ack_n;
            bus_err         <= bus_err_n;
            busy            <= busy_n;
            sram_read       <= sram_read_n;
            sram_write      <= sram_write_n;
            sram_address    <= sram_address_n;
            sram_data_write <= sram_data_write_n;
        end
    end

    always_comb begin
        state_n           = state;
        lane_n            = lane;
        wbyte_n           = wbyte;
        tcnt_n            = tcnt + 16'd1;
        bus_di_n          = bus_di;
        bus_ack_n         = 1'b0;
        bus_err_n         = 1'b0;
        busy_n            = busy;
        sram_read_n       = sram_read;
        sram_write_n      = sram_write;
        sram_address_n    = sram_address;
        sram_data_write_n = sram_data_write;
`ifdef WORD_CACHE_EN
        cvalid_n          = cvalid;
        ctag_n            = ctag;
        cdata_n           = cdata;
`endif
        case (state)
            IDLE: begin
                if (bus_read || bus_write) begin
                    lane_n         = bus_addr[0];
                    wbyte_n        = bus_do;
                    sram_address_n = bus_addr[18:1];
                    busy_n         = 1'b1;
                    tcnt_n         = '0;
`ifdef WORD_CACHE_EN
                    if (hit && !bus_write) begin
                        state_n   = ACK;
                        bus_ack_n = 1'b1;
                        bus_di_n  = pick(cdata, bus_addr[0]);
                    end else if (hit) begin
                        state_n           = WWR;
                        sram_write_n      = 1'b1;
                        sram_data_write_n = merge(cdata, bus_addr[0], bus_do);
                    end else begin
                        state_n     = bus_write ? WRD : RD;
                        sram_read_n = 1'b1;
                    end
`else
                    state_n     = bus_write ? WRD : RD;
                    sram_read_n = 1'b1;
`endif
                end
            end
            RD, WRD: begin
                if (sram_ready) begin
                    sram_read_n = 1'b0;
                    if (state == RD) begin
                        state_n   = ACK;
                        bus_ack_n = 1'b1;
                        bus_di_n  = pick(sram_data_read, lane);
`ifdef WORD_CACHE_EN
                        cvalid_n  = 1'b1;
                        ctag_n    = sram_address;
                        cdata_n   = sram_data_read;
`endif
                    end else begin
                        // Read half of the RMW: swap in the new byte, keep the other lane.
                        state_n           = WWR;
                        sram_write_n      = 1'b1;
                        sram_data_write_n = merge(sram_data_read, lane, wbyte);
                        tcnt_n            = '0;
                    end
                end else if (tmo) begin
                    sram_read_n = 1'b0;
                    state_n     = ACK;
                    bus_ack_n   = 1'b1;
                    bus_err_n   = 1'b1;
                    if (state == RD) bus_di_n = FILL_BYTE;
`ifdef WORD_CACHE_EN
                    cvalid_n    = 1'b0;
`endif
                end
            end
            WWR: begin
                if (sram_ready) begin
                    sram_write_n = 1'b0;
                    state_n      = ACK;
                    bus_ack_n    = 1'b1;
`ifdef WORD_CACHE_EN
                    cvalid_n     = 1'b1;
                    ctag_n       = sram_address;
                    cdata_n      = sram_data_write;
`endif
                end else if (tmo) begin
                    sram_write_n = 1'b0;
                    state_n      = ACK;
                    bus_ack_n    = 1'b1;
                    bus_err_n    = 1'b1;
`ifdef WORD_CACHE_EN
                    cvalid_n     = 1'b0;
`endif
                end
            end
            ACK: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sram_byte_bridge.sv
// Directed bench for sram_byte_bridge: transaction-level model fills per-cycle expectations,
// a single compare process checks them every cycle, an SRAM responder serves accesses.
module tb_sram_byte_bridge;
    localparam int         TO   = 8;
    localparam logic [7:0] FILL = 8'hFF;
    localparam int         MAXC = 4096;
`ifdef WORD_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] bus_addr = '0;
    logic [7:0]  bus_do = '0;
    logic        bus_read = 1'b0, bus_write = 1'b0;
    logic [7:0]  bus_di;
    logic        bus_ack, bus_err, busy;
    logic [17:0] sram_address;
    logic [15:0] sram_data_write;
    logic [15:0] sram_data_read = '0;
    logic        sram_read, sram_write;
    logic        sram_ready = 1'b0;

    sram_byte_bridge #(.TIMEOUT_CYCLES(TO), .FILL_BYTE(FILL)) dut (
        .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_do(bus_do),
        .bus_read(bus_read), .bus_write(bus_write), .bus_di(bus_di), .bus_ack(bus_ack),
        .bus_err(bus_err), .busy(busy), .sram_address(sram_address),
        .sram_data_write(sram_data_write), .sram_data_read(sram_data_read),
        .sram_read(sram_read), .sram_write(sram_write), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    bit rst_smp = 1'b0;
    initial forever begin
        @(posedge clk);
        rst_smp = reset;
        cyc = cyc + 1;
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Per-cycle expectations; untouched cycles mean "idle".
    bit          e_busy[MAXC], e_rd[MAXC], e_wr[MAXC], e_ack[MAXC], e_err[MAXC];
    bit          e_chka[MAXC], e_chkw[MAXC], e_diupd[MAXC];
    logic [17:0] e_addr[MAXC];
    logic [15:0] e_wd[MAXC];
    logic [7:0]  e_di[MAXC];

    logic [15:0] mm       [0:262143];
    logic [15:0] sram_mem [0:262143];
    int dly_rd = 0, dly_wr = 0;
    int ack_cyc = 0, n_ack = 0, n_rd_cyc = 0, n_rd_acc = 0, n_wr_acc = 0, last_t = 0;
    bit cv = 1'b0;
    logic [17:0] ctag = '0;

    initial begin : cmp
        logic [7:0] di_exp;
        di_exp = '0;
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < MAXC) begin
                if (rst_smp) di_exp = '0;
                if (e_diupd[cyc]) di_exp = e_di[cyc];
                chk("busy", busy, e_busy[cyc]);
                chk("sram_read", sram_read, e_rd[cyc]);
                chk("sram_write", sram_write, e_wr[cyc]);
                chk("bus_ack", bus_ack, e_ack[cyc]);
                chk("bus_err", bus_err, e_err[cyc]);
                chk("bus_di", bus_di, di_exp);
                if (e_chka[cyc]) chk("sram_address", sram_address, e_addr[cyc]);
                if (e_chkw[cyc]) chk("sram_data_write", sram_data_write, e_wd[cyc]);
                if (bus_ack === 1'b1) begin ack_cyc = cyc; n_ack++; end
                if (sram_read === 1'b1) n_rd_cyc++;
            end
        end
    end

    // SRAM responder: ready after dly strobe cycles of the current access (-1 = never).
    initial begin : sram_model
        int scnt, d;
        bit prev_rdy;
        scnt = 0; prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            sram_ready = 1'b0;
            if (sram_read === 1'b1 || sram_write === 1'b1) begin
                if (prev_rdy) scnt = 0;
                d = (sram_read === 1'b1) ? dly_rd : dly_wr;
                if (d >= 0 && scnt == d) begin
                    sram_ready = 1'b1;
                    if (sram_read === 1'b1) begin
                        sram_data_read = sram_mem[sram_address];
                        n_rd_acc++;
                    end else begin
                        sram_mem[sram_address] = sram_data_write;
                        n_wr_acc++;
                    end
                end
                scnt++;
            end else scnt = 0;
            prev_rdy = sram_ready;
        end
    end

    // One bus transaction: drive it, derive the expected cycle-by-cycle picture, wait it out.
    task automatic run_txn(input bit wr, input bit both, input logic [18:0] a, input logic [7:0] d,
                           input int kr, input int kw, input bit hold);
        int t, c, n;
        bit hit, err;
        logic [17:0] w;
        logic [15:0] m;
        t = cyc; last_t = t;
        dly_rd = kr; dly_wr = kw;
        bus_addr = a; bus_do = d; bus_write = wr; bus_read = !wr || both;
        w = a[18:1];
        hit = CACHE && cv && (ctag == w);
        err = 1'b0;
        c = t + 1;
        if (!hit) begin
            n = (kr < 0 || kr >= TO) ? TO : kr + 1;
            for (int i = 0; i < n; i++) begin e_rd[c+i] = 1'b1; e_chka[c+i] = 1'b1; e_addr[c+i] = w; end
            c += n;
            if (kr < 0 || kr >= TO) err = 1'b1;
        end
        if (wr && !err) begin
            m = mm[w];
            if (a[0]) m[15:8] = d; else m[7:0] = d;
            n = (kw < 0 || kw >= TO) ? TO : kw + 1;
            for (int i = 0; i < n; i++) begin
                e_wr[c+i] = 1'b1; e_chka[c+i] = 1'b1; e_addr[c+i] = w;
                e_chkw[c+i] = 1'b1; e_wd[c+i] = m;
            end
            c += n;
            if (kw < 0 || kw >= TO) err = 1'b1; else mm[w] = m;
        end
        for (int i = t + 1; i <= c; i++) e_busy[i] = 1'b1;
        e_ack[c] = 1'b1;
        e_err[c] = err;
        if (!wr) begin
            e_diupd[c] = 1'b1;
            m = mm[w];
            e_di[c] = err ? FILL : (a[0] ? m[15:8] : m[7:0]);
        end
        if (err) cv = 1'b0; else begin cv = 1'b1; ctag = w; end
        @(negedge clk);
        if (!hold) begin bus_read = 1'b0; bus_write = 1'b0; end
        while (cyc < c + 1) @(negedge clk);
    endtask

    // Write that is killed by reset j cycles into its first SRAM access.
    task automatic run_abort(input logic [18:0] a, input logic [7:0] d, input int j);
        int t, r;
        bit hit;
        t = cyc; r = t + 1 + j;
        dly_rd = -1; dly_wr = -1;
        bus_addr = a; bus_do = d; bus_write = 1'b1; bus_read = 1'b0;
        hit = CACHE && cv && (ctag == a[18:1]);
        for (int i = t + 1; i <= r; i++) begin
            e_busy[i] = 1'b1;
            if (hit) e_wr[i] = 1'b1; else e_rd[i] = 1'b1;
        end
        cv = 1'b0;
        @(negedge clk);
        bus_write = 1'b0;
        while (cyc < r) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, a0, c0;
        for (int i = 0; i < 262144; i++) begin mm[i] = '0; sram_mem[i] = '0; end
        mm[18'h01234] = 16'hBEEF; sram_mem[18'h01234] = 16'hBEEF;
        mm[18'h00008] = 16'hA5C3; sram_mem[18'h00008] = 16'hA5C3;
        mm[18'h00100] = 16'h7E81; sram_mem[18'h00100] = 16'h7E81;
        mm[18'h00300] = 16'h1357; sram_mem[18'h00300] = 16'h1357;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {sram_read, sram_write}, 0);
        chk("rst_ack_err", {bus_ack, bus_err}, 0);
        chk("rst_addr", sram_address, 0);
        chk("rst_wdata", sram_data_write, 0);
        chk("rst_di", bus_di, 0);
        reset = 1'b0;
        @(negedge clk);

        // Read lane 1 of 0xBEEF, ready on the third strobe cycle.
        run_txn(0, 0, 19'h02469, 8'h00, 2, 0, 0);
        chk("t1_latency", ack_cyc - last_t, 4);
        chk("t1_di", bus_di, 8'hBE);

        // Byte write to lane 0 over 0xBEEF.
        r0 = n_rd_acc; w0 = n_wr_acc;
        run_txn(1, 0, 19'h02468, 8'h5A, 1, 1, 0);
        chk("t2_sram_word", sram_mem[18'h01234], 16'hBE5A);
        chk("t2_reads", n_rd_acc - r0, CACHE ? 0 : 1);
        chk("t2_writes", n_wr_acc - w0, 1);
        run_txn(0, 0, 19'h02468, 8'h00, 0, 0, 0);
        chk("t2_readback", bus_di, 8'h5A);
        chk("t2_rb_latency", ack_cyc - last_t, CACHE ? 1 : 2);

        // Read timeout and the ready-on-last-cycle boundary on either side.
        c0 = n_rd_cyc;
        run_txn(0, 0, 19'h00200, 8'h00, -1, 0, 0);
        chk("t3_strobe_cycles", n_rd_cyc - c0, 8);
        chk("t3_di", bus_di, 8'hFF);
        chk("t3_latency", ack_cyc - last_t, 9);
        run_txn(0, 0, 19'h00201, 8'h00, 7, 0, 0);
        chk("t3_edge_ok_di", bus_di, 8'h7E);
        run_txn(0, 0, 19'h00400, 8'h00, 8, 0, 0);
        chk("t3_edge_tmo_di", bus_di, 8'hFF);

        // Write aborted in WWR leaves the word untouched.
        run_txn(1, 0, 19'h00600, 8'h99, 0, -1, 0);
        chk("wtmo_word", sram_mem[18'h00300], 16'h1357);
        run_txn(0, 0, 19'h00600, 8'h00, 0, 0, 0);
        chk("wtmo_readback", bus_di, 8'h57);

        // Read and write together take the write path; then reset lands mid-access.
        run_txn(1, 1, 19'h00601, 8'hC4, 1, 0, 0);
        chk("t4_both_word", sram_mem[18'h00300], 16'hC457);
        a0 = n_ack;
        run_abort(19'h00800, 8'h42, 2);
        chk("t4_no_ack", n_ack - a0, 0);
        chk("t4_busy", busy, 0);
        chk("t4_strobes", {sram_read, sram_write}, 0);

        // Three reads with bus_read held high.
        a0 = n_ack;
        run_txn(0, 0, 19'h02469, 8'h00, 1, 0, 1);
        run_txn(0, 0, 19'h02469, 8'h00, 1, 0, 1);
        run_txn(0, 0, 19'h02469, 8'h00, 1, 0, 0);
        chk("t5_acks", n_ack - a0, 3);
        chk("t5_di", bus_di, 8'hBE);

        // Write then neighbouring-lane read; then after a timeout the same read again.
        run_txn(1, 0, 19'h00010, 8'h77, 1, 0, 0);
        r0 = n_rd_acc;
        run_txn(0, 0, 19'h00011, 8'h00, 1, 0, 0);
        chk("t6_hit_latency", ack_cyc - last_t, CACHE ? 1 : 3);
        chk("t6_hit_reads", n_rd_acc - r0, CACHE ? 0 : 1);
        chk("t6_di", bus_di, 8'hA5);
        run_txn(0, 0, 19'h00400, 8'h00, -1, 0, 0);
        r0 = n_rd_acc;
        run_txn(0, 0, 19'h00011, 8'h00, 0, 0, 0);
        chk("t6_miss_latency", ack_cyc - last_t, 2);
        chk("t6_miss_reads", n_rd_acc - r0, 1);
        chk("t6_word", sram_mem[18'h00008], 16'hA577);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
